wb_mem_unit: RTL
================

Name: wb_mem_unit

Overview:
- Parametrised Wishbone B4 classic master used as the load/store/fetch unit of the multicycle RISC-V core.
- Sits between the control FSM and the unified memory bus.
- Adds the following over plain word-only bus access: byte/halfword/word(/doubleword) accesses, byte-lane selects, sign/zero extension, misalignment detection, bus-error capture and a watchdog timeout.
- The control FSM issues one request and waits for a single-cycle response.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, bus data width in bits; legal values 32 or 64. SEL_W = DATA_W/8; LANE_W = log2(SEL_W).
- TIMEOUT_CYCLES, 255, maximum cycles CYC may remain asserted without ACK/ERR. Only used with WB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load/fetch
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  aligned, extended load data (0 for stores/errors)
- rsp_err  out  1  response carries an error
- rsp_err_code  out  2  00 none, 01 misaligned/illegal size, 10 bus ERR, 11 timeout
- wb_adr_o  out  ADDR_W  address with low LANE_W bits cleared
- wb_dat_o  out  DATA_W  lane-replicated store data
- wb_sel_o  out  SEL_W  byte-lane select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_dat_i  in  DATA_W  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error

Behaviour:
- Single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE, req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_err_code=00, rsp_rdata=0.
  - wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0.
- FSM states: IDLE, BUS, RESP.
- IDLE: on accept, register addr/size/we/wdata.
  - Legal and aligned request → BUS. Bus outputs are registered and asserted from the next cycle.
  - Otherwise → RESP with code 01; no bus cycle is issued.
- Alignment rules:
  - H requires addr[0]=0.
  - W requires addr[1:0]=0.
  - D requires addr[2:0]=0.
  - Sizes 011/110 when DATA_W=32, and 111 always, are illegal (code 01).
- Lane handling:
  - lane = addr[LANE_W-1:0].
  - sel is 1, 3, 0xF or 0xFF (by size), shifted left by lane.
  - wb_dat_o = req_wdata's low byte/half/word replicated across DATA_W.
- BUS: cyc=stb=1, held stable until termination.
  - ACK → capture wb_dat_i, → RESP, deassert cyc/stb the next cycle.
  - ERR → RESP, code 10.
  - ACK and ERR in the same cycle: ERR wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 during RESP.
- rsp_rdata = (dat_i >> lane*8), truncated to size, sign-extended for B/H/W and zero-extended for BU/HU/WU. It is 0 for stores and errors.
- Latency: accept in cycle N, cyc from N+1. ACK sampled in cycle M gives rsp_valid in M+1. Minimum load-to-response is 3 cycles with zero-wait ACK. Misaligned requests respond at N+1.
- No response backpressure. The requester must consume the rsp_valid pulse.
- ACK/ERR seen in IDLE or RESP is ignored.
- rst asserted mid-BUS drops cyc/stb immediately (asynchronously); the pending request is discarded with no response.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - An 8..16-bit counter (width sized to TIMEOUT_CYCLES) clears on entering BUS and increments each BUS cycle.
  - Reaching TIMEOUT_CYCLES with no ACK/ERR → drop cyc/stb, → RESP, code 11.
  - ACK on the same cycle the counter reaches the limit wins over the timeout.
- WB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely and code 11 is never produced.

Decomposition:
- Package wb_mem_pkg holds:
  - size encodings (SZ_B..SZ_WU)
  - err codes (ERR_NONE, ERR_ALIGN, ERR_BUS, ERR_TIMEOUT)
  - FSM state enum
- Sub-module wb_lane_align is combinational and parametrised by DATA_W. It generates sel and replicated write data, detects misalignment and illegal sizes, and extracts/extends read data. It is instantiated once.
- The FSM, registers and timeout counter stay in wb_mem_unit.

Test Plan:
- Aligned word load at 0x100, dat_i=0xDEADBEEF, ACK after 2 wait states → sel=0xF, adr=0x100, rsp_rdata=0xDEADBEEF, rsp_valid in the cycle after ACK, err=0.
- LB at 0x103, dat_i=0x80AABBCC → sel=0x8, rsp_rdata=0xFFFFFF80. LBU at the same address → rsp_rdata=0x00000080.
- SH at 0x202, wdata=0x0000_1234 → we=1, sel=0xC, dat_o=0x12341234, adr=0x200.
- LW at 0x101 → no cyc asserted, rsp_valid at N+1, rsp_err=1, code 01.
- Word store with wb_err_i and wb_ack_i asserted together → code 10, cyc low the next cycle. With WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK → code 11 after 4 BUS cycles.
- rst pulsed while cyc=1 → cyc/stb low immediately, req_ready=1, no rsp_valid. A later ACK is ignored.

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone load/store/fetch unit:
// funct3 size encodings, response error codes, FSM states and a helper
// that sizes the optional watchdog counter.
package wb_mem_pkg;

    // funct3-style access size encodings (111 is always illegal)
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    // Response error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Watchdog counter width: enough to hold the limit, clamped to 8..16 bits
    function automatic int tmo_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8) begin
            return 8;
        end
        if (w > 16) begin
            return 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_mem_if.sv
// Wishbone B4 classic bus bundle between the memory unit (master) and
// the unified memory (slave).
interface wb_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wb_lane_align.sv
// Combinational byte-lane helper: builds the lane select and replicated
// store data, flags misaligned/illegal sizes, and aligns plus sign/zero
// extends read data from the bus.
module wb_lane_align
    import wb_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          size,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_raw,
    output logic [DATA_W/8-1:0] sel,
    output logic [DATA_W-1:0]   wdata_rep,
    output logic                bad,
    output logic [DATA_W-1:0]   rdata_ext
);
    localparam int SEL_W  = DATA_W / 8;
    localparam int LANE_W = $clog2(SEL_W);

    logic [1:0]        width_code;
    logic [LANE_W-1:0] lane;
    logic [SEL_W-1:0]  keep;
    logic [DATA_W-1:0] shifted;
    logic              illegal;
    logic              misaligned;
    logic              sign_bit;
    logic              ext_bit;

    assign width_code = size[1:0];
    assign lane       = addr_lo[LANE_W-1:0];

    // Bytes covered by the access, before shifting onto the lane
    always_comb begin
        case (width_code)
            2'b00:   keep = SEL_W'(1);
            2'b01:   keep = SEL_W'(3);
            2'b10:   keep = SEL_W'(15);
            default: keep = '1;
        endcase
    end

    assign sel = keep << lane;

    // Size legality and natural-alignment check
    always_comb begin
        illegal = (size == 3'b111) ||
                  ((DATA_W == 32) && ((size == SZ_D) || (size == SZ_WU)));
        case (width_code)
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo[1:0] != 2'b00);
            2'b11:   misaligned = (addr_lo[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    assign bad = illegal | misaligned;

    // Bring the addressed lane down to bit 0
    assign shifted = rdata_raw >> {lane, 3'b000};

    // Pick the top bit of the accessed field for sign extension
    always_comb begin
        case (width_code)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
    end

    // Unsigned variants (size[2] set) always fill with zeros
    assign ext_bit = ~size[2] & sign_bit;

    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_byte
        logic [7:0] wbyte;

        assign rdata_ext[gi*8 +: 8] = keep[gi] ? shifted[gi*8 +: 8] : {8{ext_bit}};

        // Replicate the low byte/half/word of the store data into every lane
        always_comb begin
            case (width_code)
                2'b00:   wbyte = wdata[7:0];
                2'b01:   wbyte = wdata[(gi % 2)*8 +: 8];
                2'b10:   wbyte = wdata[(gi % 4)*8 +: 8];
                default: wbyte = wdata[gi*8 +: 8];
            endcase
        end

        assign wdata_rep[gi*8 +: 8] = wbyte;
    end

endmodule

// File: rtl/wb_mem_unit.sv
// Wishbone B4 classic load/store/fetch master for the multicycle core.
// Accepts one request at a time, runs a single bus cycle and returns a
// one-cycle response with aligned/extended load data or an error code.
// Optional watchdog: define WB_TIMEOUT_EN to abort bus cycles that see
// no ACK/ERR within TIMEOUT_CYCLES cycles (error code 11).
module wb_mem_unit
    import wb_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_err_code,
    wb_mem_if.master          wb
);
    localparam int SEL_W  = DATA_W / 8;
    localparam int LANE_W = $clog2(SEL_W);

    state_e            state;
    logic [2:0]        size_reg;
    logic [2:0]        addr_lo_reg;
    logic              we_reg;

    logic [2:0]        al_size;
    logic [2:0]        al_addr;
    logic [SEL_W-1:0]  al_sel;
    logic [DATA_W-1:0] al_wdata;
    logic              al_bad;
    logic [DATA_W-1:0] al_rdata;
    logic              accept;
    logic              tmo_hit;

    assign accept = req_valid & req_ready;

    // Aligner sees the live request while idle, the latched one afterwards
    always_comb begin
        if (state == ST_IDLE) begin
            al_size = req_size;
            al_addr = req_addr[2:0];
        end else begin
            al_size = size_reg;
            al_addr = addr_lo_reg;
        end
    end

    wb_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size      (al_size),
        .addr_lo   (al_addr),
        .wdata     (req_wdata),
        .rdata_raw (wb.wb_dat_i),
        .sel       (al_sel),
        .wdata_rep (al_wdata),
        .bad       (al_bad),
        .rdata_ext (al_rdata)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // The last BUS cycle of the budget is the one where the count reads limit-1
    assign tmo_hit = (state == ST_BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared when a bus cycle starts, counts every BUS cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Control FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            size_reg     <= '0;
            addr_lo_reg  <= '0;
            we_reg       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
            wb.wb_adr_o  <= '0;
            wb.wb_dat_o  <= '0;
            wb.wb_sel_o  <= '0;
            wb.wb_we_o   <= 1'b0;
            wb.wb_cyc_o  <= 1'b0;
            wb.wb_stb_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_reg    <= req_size;
                        addr_lo_reg <= req_addr[2:0];
                        we_reg      <= req_we;
                        req_ready   <= 1'b0;
                        if (al_bad) begin
                            // Reject without touching the bus
                            state        <= ST_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b1;
                            rsp_err_code <= ERR_ALIGN;
                            rsp_rdata    <= '0;
                        end else begin
                            state       <= ST_BUS;
                            wb.wb_adr_o <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            wb.wb_dat_o <= al_wdata;
                            wb.wb_sel_o <= al_sel;
                            wb.wb_we_o  <= req_we;
                            wb.wb_cyc_o <= 1'b1;
                            wb.wb_stb_o <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (wb.wb_err_i || wb.wb_ack_i || tmo_hit) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        // ERR beats ACK; ACK beats the watchdog
                        if (wb.wb_err_i) begin
                            rsp_err      <= 1'b1;
                            rsp_err_code <= ERR_BUS;
                            rsp_rdata    <= '0;
                        end else if (wb.wb_ack_i) begin
                            rsp_err      <= 1'b0;
                            rsp_err_code <= ERR_NONE;
                            rsp_rdata    <= we_reg ? '0 : al_rdata;
                        end else begin
                            rsp_err      <= 1'b1;
                            rsp_err_code <= ERR_TIMEOUT;
                            rsp_rdata    <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    req_ready    <= 1'b1;
                    rsp_valid    <= 1'b0;
                    rsp_err      <= 1'b0;
                    rsp_err_code <= ERR_NONE;
                    rsp_rdata    <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
